// File: rtl/fetch_unit_bj_if.sv
// Fetch-unit bus bundle.
// Groups the instruction-memory request/response handshake and the
// instruction delivery handshake towards decode into one interface.
//   imem_req/imem_addr   : request valid and word-aligned fetch address
//   imem_gnt             : request accepted this cycle
//   imem_rvalid/rdata    : in-order read response
//   instr_valid/code/pc  : head of the instruction buffer
//   instr_ready          : consumer takes the head when valid && ready
// Modports: master = fetch unit side, slave = memory/decode side.
interface fetch_unit_bj_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr_code;
    logic [31:0] instr_pc;
    logic        instr_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output instr_valid, instr_code, instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  instr_valid, instr_code, instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/fetch_unit_bj.sv
// Instruction-fetch stage for the single-cycle RV32 core.
// Owns the fetch PC, issues word requests to instruction memory, buffers the
// returned words (with their PCs) in a small FIFO and hands them to decode
// under valid/ready. A redirect discards buffered and in-flight work and
// restarts fetching at the new target.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   redirect     : one-cycle pulse, restart fetching at redirect_pc
//   redirect_pc  : new fetch target (low two bits ignored)
//   bus          : fetch_unit_bj_if master (imem_* and instr_* signals)
module fetch_unit_bj #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [31:0]     redirect_pc,
    fetch_unit_bj_if.master bus
);
    localparam int          PTR_W = $clog2(FIFO_DEPTH);
    localparam int          CNT_W = PTR_W + 1;
    localparam int          SUM_W = CNT_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_DRAIN} state_t;

    state_t             state_reg;
    logic [31:0]        fpc_reg;
    logic [31:0]        rpc_reg;
    logic [CNT_W-1:0]   out_cnt_reg;
    logic [CNT_W-1:0]   out_cnt_next;
    logic [CNT_W-1:0]   fifo_cnt_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [31:0]        entry_code [FIFO_DEPTH];
    logic [31:0]        entry_pc   [FIFO_DEPTH];

    logic               credit_ok;
    logic               redirect_act;
    logic               grant;
    logic               rsp_ok;
    logic               push;
    logic               pop;
    logic               fifo_has;
    logic [31:0]        target_pc;

    assign target_pc    = redirect_pc & 32'hFFFF_FFFC;

    // Outstanding requests plus buffered words may never exceed the FIFO
    // size, so every response that comes back is guaranteed a slot.
    assign credit_ok    = ({1'b0, out_cnt_reg} + {1'b0, fifo_cnt_reg}) < SUM_W'(FIFO_DEPTH);
    assign redirect_act = redirect && (state_reg != ST_BOOT);

    assign bus.imem_req  = (state_reg == ST_RUN) && !redirect && credit_ok;
    assign bus.imem_addr = fpc_reg;

    assign grant    = bus.imem_req && bus.imem_gnt;
    // A response with nothing outstanding is a protocol violation; drop it
    // so the counter cannot underflow.
    assign rsp_ok   = bus.imem_rvalid && (out_cnt_reg != '0);
    // Responses are only kept in RUN; in DRAIN (or under a redirect) they
    // belong to the abandoned path and only retire their credit.
    assign push     = rsp_ok && (state_reg == ST_RUN) && !redirect;
    assign fifo_has = (fifo_cnt_reg != '0);
    assign pop      = fifo_has && bus.instr_ready && !redirect_act;

    assign out_cnt_next = out_cnt_reg + CNT_W'(grant) - CNT_W'(rsp_ok);

    // Instruction buffer storage, one register pair per entry.
    genvar gi;
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
        logic [31:0] code_q;
        logic [31:0] pc_q;

        always_ff @(posedge clk) begin
            if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                code_q <= bus.imem_rdata;
                pc_q   <= rpc_reg;
            end
        end

        assign entry_code[gi] = code_q;
        assign entry_pc[gi]   = pc_q;
    end

    assign bus.instr_valid = fifo_has;
    assign bus.instr_code  = fifo_has ? entry_code[rd_ptr_reg] : NOP;
    assign bus.instr_pc    = fifo_has ? entry_pc[rd_ptr_reg]   : rpc_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_BOOT;
            fpc_reg      <= RESET_PC;
            rpc_reg      <= RESET_PC;
            out_cnt_reg  <= '0;
            fifo_cnt_reg <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            out_cnt_reg <= out_cnt_next;
            case (state_reg)
                ST_BOOT: begin
                    // One idle cycle after reset before the first request.
                    state_reg <= ST_RUN;
                end
                default: begin
                    if (redirect) begin
                        fpc_reg      <= target_pc;
                        rpc_reg      <= target_pc;
                        fifo_cnt_reg <= '0;
                        wr_ptr_reg   <= '0;
                        rd_ptr_reg   <= '0;
                        // Old-path responses still in flight must be drained
                        // before new requests go out, otherwise they would be
                        // mistaken for new-path data.
                        state_reg    <= (out_cnt_next == '0) ? ST_RUN : ST_DRAIN;
                    end else begin
                        if (grant) begin
                            fpc_reg <= fpc_reg + 32'd4;
                        end
                        if (push) begin
                            rpc_reg    <= rpc_reg + 32'd4;
                            wr_ptr_reg <= wr_ptr_reg + 1'b1;
                        end
                        if (pop) begin
                            rd_ptr_reg <= rd_ptr_reg + 1'b1;
                        end
                        fifo_cnt_reg <= fifo_cnt_reg + CNT_W'(push) - CNT_W'(pop);
                        if ((state_reg == ST_DRAIN) && (out_cnt_next == '0)) begin
                            state_reg <= ST_RUN;
                        end
                    end
                end
            endcase
        end
    end
endmodule
